// File: rtl/mips_stage_hazard_if.sv
// Purpose : bundle of register-port, EX-stage and control signals between the
//           pipeline datapath and the hazard/stall controller.
// Ports   : master = pipeline side (drives ID/EX info, receives stall/flush);
//           slave  = hazard controller (consumes ID/EX info, drives stall/flush).
//           Perf counter outputs exist only when MIPS_STAGE_HAZARD_PERF_EN is defined.
interface mips_stage_hazard_if;
   logic [4:0]  idRs;
   logic [4:0]  idRt;
   logic        idUsesRs;
   logic        idUsesRt;
   logic        idUsesHiLo;
   logic        exMemRead;
   logic [4:0]  exDest;
   logic        exMulDiv;
   logic        exBranchTaken;
   logic        stallPc;
   logic        stallIfId;
   logic        flushIfId;
   logic        flushIdEx;
   logic        mulDivBusy;
`ifdef MIPS_STAGE_HAZARD_PERF_EN
   logic [31:0] stallCycles;
   logic [31:0] flushCycles;
   logic [31:0] mulDivWaitCycles;
`endif

   modport master (
      output idRs, idRt, idUsesRs, idUsesRt, idUsesHiLo,
      output exMemRead, exDest, exMulDiv, exBranchTaken,
      input  stallPc, stallIfId, flushIfId, flushIdEx, mulDivBusy
`ifdef MIPS_STAGE_HAZARD_PERF_EN
      , input stallCycles, flushCycles, mulDivWaitCycles
`endif
   );

   modport slave (
      input  idRs, idRt, idUsesRs, idUsesRt, idUsesHiLo,
      input  exMemRead, exDest, exMulDiv, exBranchTaken,
      output stallPc, stallIfId, flushIfId, flushIdEx, mulDivBusy
`ifdef MIPS_STAGE_HAZARD_PERF_EN
      , output stallCycles, flushCycles, mulDivWaitCycles
`endif
   );
endinterface

// File: rtl/mips_stage_hazard.sv
// Purpose : hazard/stall controller: load-use, HI/LO busy wait, taken-branch flush; owns mult/div busy timer.
// Latency : stall/flush outputs are combinational (zero cycles); mulDivBusy rises the cycle after mult/div issue.
// Backpres: stall holds PC and IF/ID and bubbles ID/EX; a taken branch flushes and overrides every stall.
// Ports   : clock (rising edge), resetN (async active-low), hz (slave modport of mips_stage_hazard_if).
// Options : MIPS_STAGE_HAZARD_PERF_EN adds saturating stallCycles/flushCycles/mulDivWaitCycles counters.
module mips_stage_hazard #(
   parameter int MULDIV_CYCLES = 32,
   parameter int CNT_WIDTH     = 6
) (
   input  logic               clock,
   input  logic               resetN,
   mips_stage_hazard_if.slave hz
);
   localparam logic [CNT_WIDTH-1:0] LP_RELOAD = CNT_WIDTH'(MULDIV_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] LP_ONE    = CNT_WIDTH'(1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t               r_state;
   state_t               w_stateNext;
   logic [CNT_WIDTH-1:0] r_count;
   logic [CNT_WIDTH-1:0] w_countNext;
   logic                 w_start;
   logic                 w_busy;
   logic                 w_loadUse;
   logic                 w_hiloWait;
   logic                 w_stall;

   // A mult/div alongside a taken branch is wrong-path and never starts.
   assign w_start = hz.exMulDiv & ~hz.exBranchTaken;
   assign w_busy  = (r_state == ST_BUSY);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state <= ST_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_stateNext;
         r_count <= w_countNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_countNext = r_count;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_stateNext = ST_BUSY;
               w_countNext = LP_RELOAD;
            end
         end
         ST_BUSY: begin
            if (w_start) begin
               // Illegal overlap (ID should have stalled it); restart the timer.
               w_countNext = LP_RELOAD;
            end else if (r_count <= LP_ONE) begin
               w_stateNext = ST_IDLE;
               w_countNext = '0;
            end else begin
               w_countNext = r_count - LP_ONE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
            w_countNext = '0;
         end
      endcase
   end

   // $0 is hardwired, so a load targeting it never creates a dependency.
   assign w_loadUse  = hz.exMemRead & (hz.exDest != 5'd0) &
                       ((hz.idUsesRs & (hz.idRs == hz.exDest)) |
                        (hz.idUsesRt & (hz.idRt == hz.exDest)));
   // exMulDiv covers the issue cycle, before the busy timer has started.
   assign w_hiloWait = hz.idUsesHiLo & (w_busy | hz.exMulDiv);
   assign w_stall    = (w_loadUse | w_hiloWait) & ~hz.exBranchTaken;

   assign hz.stallPc    = w_stall;
   assign hz.stallIfId  = w_stall;
   assign hz.flushIfId  = hz.exBranchTaken;
   assign hz.flushIdEx  = w_stall | hz.exBranchTaken;
   assign hz.mulDivBusy = w_busy;

`ifdef MIPS_STAGE_HAZARD_PERF_EN
   logic [31:0] r_stallCycles;
   logic [31:0] r_flushCycles;
   logic [31:0] r_mulDivWaitCycles;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_stallCycles      <= '0;
         r_flushCycles      <= '0;
         r_mulDivWaitCycles <= '0;
      end else begin
         if (w_stall && (r_stallCycles != 32'hFFFF_FFFF))
            r_stallCycles <= r_stallCycles + 32'd1;
         if (hz.exBranchTaken && (r_flushCycles != 32'hFFFF_FFFF))
            r_flushCycles <= r_flushCycles + 32'd1;
         if (w_hiloWait && w_stall && (r_mulDivWaitCycles != 32'hFFFF_FFFF))
            r_mulDivWaitCycles <= r_mulDivWaitCycles + 32'd1;
      end
   end

   assign hz.stallCycles      = r_stallCycles;
   assign hz.flushCycles      = r_flushCycles;
   assign hz.mulDivWaitCycles = r_mulDivWaitCycles;
`endif
endmodule

// File: doc/mips_stage_hazard.md
Name: mips_stage_hazard

Overview:
- Hazard/stall controller feeding the pipeline registers.
- Consumes the same register-port and pipeline-stage information that the EX forwarding path uses, and decides the cases forwarding cannot cover: load-use, busy multiply/divide unit, taken-branch wrong path.
- Drives stall and flush controls into PC, IF/ID and ID/EX.
- Owns the multi-cycle mult/div busy timer.

Parameters:
- MULDIV_CYCLES, 32: total cycles a mult/div occupies HI/LO after issue from EX; legal range 2..63.
- CNT_WIDTH, 6: busy counter width; must satisfy 2^CNT_WIDTH > MULDIV_CYCLES.

Ports:
- clock  input  1  pipeline clock, rising edge.
- resetN  input  1  asynchronous active-low reset.
- idRs  input  5  rs number of the instruction in ID.
- idRt  input  5  rt number of the instruction in ID.
- idUsesRs  input  1  ID instruction reads rs.
- idUsesRt  input  1  ID instruction reads rt.
- idUsesHiLo  input  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div.
- exMemRead  input  1  EX instruction is a load.
- exDest  input  5  EX destination register.
- exMulDiv  input  1  EX instruction is mult/multu/div/divu.
- exBranchTaken  input  1  branch/jump resolved taken in EX.
- stallPc  output  1  hold PC.
- stallIfId  output  1  hold IF/ID register.
- flushIfId  output  1  zero IF/ID on next edge.
- flushIdEx  output  1  insert bubble into ID/EX on next edge.
- mulDivBusy  output  1  HI/LO not yet valid.

Behaviour:
- Reset (resetN=0, asynchronous): busy counter=0 and state=IDLE immediately. All outputs 0 while reset is held and in the first cycle after release, unless inputs create a combinational hazard.
- State machine, two states:
  - IDLE: counter=0, mulDivBusy=0.
  - BUSY: counter>0, mulDivBusy=1.
- IDLE->BUSY: rising edge with exMulDiv=1 and exBranchTaken=0. Counter loads MULDIV_CYCLES-1.
- BUSY: counter decrements every edge. The edge on which counter=1 moves to IDLE with counter=0, so mulDivBusy is high for exactly MULDIV_CYCLES-1 cycles after the issue edge.
- exMulDiv=1 while BUSY cannot occur legally, because ID stalls it. If it is asserted anyway, the counter reloads MULDIV_CYCLES-1.
- loadUse (combinational): exMemRead & exDest!=0 & ((idUsesRs & idRs==exDest) | (idUsesRt & idRt==exDest)).
- hiloWait (combinational): idUsesHiLo & (mulDivBusy | exMulDiv).
- stall = (loadUse | hiloWait) & ~exBranchTaken.
- stall=1 drives stallPc=1, stallIfId=1, flushIdEx=1 in the same cycle, with zero latency.
- Load-use produces exactly one bubble: next cycle the load is in MEM and forwarding supplies the value.
- exBranchTaken=1 (combinational):
  - flushIfId=1, flushIdEx=1, stallPc=0, stallIfId=0.
  - The flush has priority over every stall because the ID instruction is wrong-path.
- Simultaneous taken branch and mult/div in EX: the mult/div is itself the branch delay-free EX instruction and is not started. Branch in EX implies EX is not mult/div, so this is defensive only.
- Register $0 is never a hazard source.
- The counter never wraps. Decrement is gated by counter!=0.
- All outputs are combinational functions of the inputs and registered state. No registered outputs.
- Reset asserted mid-countdown: busy drops at once. HI/LO consumers are reset too.

Optional Feature:
- Macro: MIPS_STAGE_HAZARD_PERF_EN.
- When defined, adds three output ports:
  - stallCycles (32): counts cycles with stall=1.
  - flushCycles (32): counts cycles with exBranchTaken=1.
  - mulDivWaitCycles (32): counts cycles with hiloWait & stall.
- All three counters saturate at 32'hFFFFFFFF and clear on asynchronous reset.
- When undefined: ports, counters and related logic are absent. Stall/flush behaviour is identical in both builds.

Test Plan:
- Load-use: exMemRead=1, exDest=8, idRs=8, idUsesRs=1 -> stallPc=stallIfId=flushIdEx=1 for one cycle. Next cycle with exMemRead=0 -> all 0.
- $0 and no-use filter:
  - exMemRead=1, exDest=0, idRs=0, idUsesRs=1 -> no stall.
  - exDest=9, idRt=9, idUsesRt=0 -> no stall.
- Mult/div timer with MULDIV_CYCLES=4:
  - exMulDiv=1 for one edge -> mulDivBusy=1 for 3 cycles, then 0.
  - idUsesHiLo=1 throughout -> stall every cycle from the exMulDiv cycle until mulDivBusy falls, then 0.
- Branch priority: exBranchTaken=1 together with a loadUse match -> flushIfId=flushIdEx=1, stallPc=stallIfId=0.
- Async reset mid-busy: with counter=20, pull resetN low between edges -> mulDivBusy=0 immediately. After release, idUsesHiLo=1 causes no stall.
- PERF build:
  - 5 load-use stalls plus 2 branches -> stallCycles=5, flushCycles=2.
  - Force stallCycles to 32'hFFFFFFFE, then apply 3 stalls -> stallCycles holds at 32'hFFFFFFFF.
